// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multichannel PWM block.
package pwm_pkg;

  // Default geometry, matching the original three-channel RGB use.
  localparam int DEF_NCH     = 3;
  localparam int DEF_DUTY_W  = 8;
  localparam int DEF_PRESC_W = 8;

  // Counting-mode encoding, as presented on center_mode.
  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  // Width of a channel-select field; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared prescaler and period counter. Generates the period boundary and
// holds the configuration that is latched at each boundary.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int DUTY_W  = DEF_DUTY_W,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               center_mode,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [DUTY_W-1:0]  period,
  output logic [DUTY_W-1:0]  cnt,
  output logic               cnt_dir,
  output logic               boundary,
  output logic               period_tick
);

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] prescale_act;
  logic [DUTY_W-1:0]  cnt_q;
  logic [DUTY_W-1:0]  cnt_nxt;
  logic [DUTY_W-1:0]  period_act;
  logic               dir_q;
  logic               dir_nxt;
  logic               mode_act;
  logic               first_q;
  logic               tick_q;
  logic               tick;
  logic               at_end;

  // Tick, end-of-period detection and next counter value.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no
    // path through the branches below can leave it unassigned (no latch).
    cnt_nxt = cnt_q;
    dir_nxt = dir_q;
    tick    = enable && (presc_q == prescale_act);

    if (mode_act == MODE_EDGE) begin
      at_end = (cnt_q >= period_act);
    end else begin
      // Center mode with a zero period never leaves 0, so every tick ends it.
      at_end = (period_act == '0) || (dir_q && (cnt_q <= DUTY_W'(1)));
    end

    // The first tick after enable rises also counts as a boundary so the
    // configuration is fresh before any output can toggle.
    boundary = tick && (first_q || at_end);

    if (!enable || boundary) begin
      cnt_nxt = '0;
      dir_nxt = 1'b0;
    end else if (tick) begin
      if (mode_act == MODE_EDGE) begin
        cnt_nxt = cnt_q + 1'b1;
      end else if (!dir_q) begin
        if (cnt_q >= period_act - 1'b1) begin
          cnt_nxt = period_act;
          dir_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end else begin
        cnt_nxt = cnt_q - 1'b1;
      end
    end
  end

  // Prescaler, counter, boundary pulse and configuration latching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      period_act   <= '0;
      prescale_act <= '0;
      mode_act     <= MODE_EDGE;
      first_q      <= 1'b1;
      tick_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge value of the others, independent of statement order.
      presc_q <= (!enable || tick) ? '0 : presc_q + 1'b1;
      cnt_q   <= cnt_nxt;
      dir_q   <= dir_nxt;
      tick_q  <= boundary;
      if (!enable) begin
        first_q <= 1'b1;
      end else if (boundary) begin
        first_q <= 1'b0;
      end
      if (boundary) begin
        period_act   <= period;
        prescale_act <= prescale;
        mode_act     <= center_mode;
      end
    end
  end

  assign cnt         = cnt_q;
  assign cnt_dir     = dir_q;
  assign period_tick = tick_q;

endmodule

// File: rtl/pwm_multichannel.sv
// N-channel PWM: one shared timebase, per-channel double-buffered duty
// registers and registered, optionally inverted compare outputs.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int             NCH        = DEF_NCH,
  parameter int             DUTY_W     = DEF_DUTY_W,
  parameter int             PRESC_W    = DEF_PRESC_W,
  parameter logic [NCH-1:0] OUT_INVERT = '0,
  localparam int            SEL_W      = sel_width(NCH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               center_mode,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [DUTY_W-1:0]  period,
  input  logic               duty_wr,
  input  logic [SEL_W-1:0]   duty_sel,
  input  logic [DUTY_W-1:0]  duty_data,
  output logic [NCH-1:0]     pwm_out,
  output logic               period_tick,
  output logic               cnt_dir
);

  logic [DUTY_W-1:0] cnt;
  logic              boundary;
  logic              wr_ok;

  pwm_timebase #(
    .DUTY_W  (DUTY_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk         (clk),
    .rst         (reset),
    .enable      (enable),
    .center_mode (center_mode),
    .prescale    (prescale),
    .period      (period),
    .cnt         (cnt),
    .cnt_dir     (cnt_dir),
    .boundary    (boundary),
    .period_tick (period_tick)
  );

  // Out-of-range channel indices are dropped rather than aliased.
  assign wr_ok = duty_wr && (int'(duty_sel) < NCH);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DUTY_W-1:0] shadow;
    logic [DUTY_W-1:0] active;
    logic              pwm_q;
    logic              wr_hit;

    assign wr_hit = wr_ok && (duty_sel == SEL_W'(i));

    // Shadow capture, and shadow-to-active transfer at the boundary; a write
    // landing on the boundary edge bypasses straight into active.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        // NOTE: the duty registers are reset on purpose: a reset must leave
        // every channel at 0 % rather than replaying a stale duty.
        shadow <= '0;
        active <= '0;
      end else begin
        if (wr_hit) begin
          shadow <= duty_data;
        end
        if (boundary) begin
          active <= wr_hit ? duty_data : shadow;
        end
      end
    end

    // Registered compare output; idle level is the inversion bit.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pwm_q <= OUT_INVERT[i];
      end else if (!enable) begin
        pwm_q <= OUT_INVERT[i];
      end else begin
        pwm_q <= (cnt < active) ^ OUT_INVERT[i];
      end
    end

    assign pwm_out[i] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: three channels, channel 1 inverted.
module tb_pwm_multichannel;

  localparam logic [2:0] INV = 3'b010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       center_mode = 1'b0;
  logic [7:0] prescale = '0;
  logic [7:0] period = '0;
  logic       duty_wr = 1'b0;
  logic [1:0] duty_sel = '0;
  logic [7:0] duty_data = '0;
  logic [2:0] pwm_out;
  logic       period_tick;
  logic       cnt_dir;

  int checks = 0;
  int fails  = 0;

  // Results of the most recent measurement window.
  int hi_cnt[3];
  int first_low[3];
  int tick_at, tick_n, dir_n, first_dir;

  pwm_multichannel #(
    .NCH        (3),
    .DUTY_W     (8),
    .PRESC_W    (8),
    .OUT_INVERT (INV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .center_mode (center_mode),
    .prescale    (prescale),
    .period      (period),
    .duty_wr     (duty_wr),
    .duty_sel    (duty_sel),
    .duty_data   (duty_data),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .cnt_dir     (cnt_dir)
  );

  always #5 clk = ~clk;

  // Sample n falling edges; record high counts (de-inverted), first low
  // sample per channel, period_tick position and cnt_dir activity.
  task automatic measure(input int n);
    logic [2:0] raw;
    for (int i = 0; i < 3; i++) begin
      hi_cnt[i]    = 0;
      first_low[i] = n;
    end
    tick_at = -1; tick_n = 0; dir_n = 0; first_dir = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      raw = pwm_out ^ INV;
      for (int i = 0; i < 3; i++) begin
        if (raw[i]) hi_cnt[i]++;
        else if (first_low[i] == n) first_low[i] = k;
      end
      if (period_tick) begin tick_at = k; tick_n++; end
      if (cnt_dir) begin dir_n++; if (first_dir < 0) first_dir = k; end
    end
  endtask

  // Advance to the falling edge on which period_tick is high (bounded).
  task automatic wait_tick(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (period_tick !== 1'b1 && k < 200);
    checks++;
    if (period_tick !== 1'b1) begin
      fails++;
      $display("FAIL %s_wait_tick: no period_tick within %0d clks", tag, k);
    end
  endtask

  task automatic write_duty(input logic [1:0] sel, input logic [7:0] data);
    duty_wr = 1'b1; duty_sel = sel; duty_data = data;
    @(negedge clk);
    duty_wr = 1'b0;
  endtask

  task automatic check_hi(input string tag, input int e0, input int e1, input int e2);
    checks++;
    if (hi_cnt[0] !== e0 || hi_cnt[1] !== e1 || hi_cnt[2] !== e2) begin
      fails++;
      $display("FAIL %s: high clks got %0d/%0d/%0d expected %0d/%0d/%0d",
               tag, hi_cnt[0], hi_cnt[1], hi_cnt[2], e0, e1, e2);
    end
  endtask

  task automatic check_tick(input string tag, input int e_at);
    checks++;
    if (tick_at !== e_at || tick_n !== ((e_at < 0) ? 0 : 1)) begin
      fails++;
      $display("FAIL %s: period_tick at %0d (count %0d) expected at %0d",
               tag, tick_at, tick_n, e_at);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (pwm_out !== INV || period_tick !== 1'b0 || cnt_dir !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: pwm_out=%b tick=%b dir=%b expected %b/0/0",
               pwm_out, period_tick, cnt_dir, INV);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Edge mode, period 9, prescale 0: 10-clk period, duty 3 high then low.
  task automatic test_edge();
    period = 8'd9; prescale = 8'd0; center_mode = 1'b0;
    write_duty(2'd0, 8'd3);
    write_duty(2'd1, 8'd5);
    write_duty(2'd2, 8'd10);
    enable = 1'b1;
    wait_tick("edge");
    measure(10);
    check_hi("edge_p1", 3, 5, 10);
    check_tick("edge_p1_tick", 9);
    checks++;
    if (first_low[0] !== 3 || dir_n !== 0) begin
      fails++;
      $display("FAIL edge_shape: first low %0d dir samples %0d expected 3/0",
               first_low[0], dir_n);
    end
    measure(10);
    check_hi("edge_p2", 3, 5, 10);
    check_tick("edge_p2_tick", 9);
  endtask

  // Duty 0 is always low, duty > period always high, duty 9 gives 9/1.
  task automatic test_duty_bounds();
    write_duty(2'd0, 8'd0);
    write_duty(2'd1, 8'd10);
    write_duty(2'd2, 8'd9);
    wait_tick("bounds");
    measure(10);
    check_hi("duty_bounds", 0, 10, 9);
    checks++;
    if (first_low[2] !== 9) begin
      fails++;
      $display("FAIL duty9_shape: first low at %0d expected 9", first_low[2]);
    end
  endtask

  // Mid-period write waits for the boundary; a boundary write bypasses.
  task automatic test_shadow_update();
    write_duty(2'd1, 8'd2);
    wait_tick("shadow");
    measure(5);
    write_duty(2'd1, 8'd7);
    checks++;
    if (hi_cnt[1] !== 2) begin
      fails++;
      $display("FAIL shadow_before: ch1 high %0d expected 2", hi_cnt[1]);
    end
    measure(4);
    checks++;
    if (hi_cnt[1] !== 0 || tick_at !== 3) begin
      fails++;
      $display("FAIL shadow_rest: ch1 high %0d tick %0d expected 0/3", hi_cnt[1], tick_at);
    end
    measure(10);
    check_hi("shadow_after", 0, 7, 9);
    measure(9);
    duty_wr = 1'b1; duty_sel = 2'd1; duty_data = 8'd4;
    @(negedge clk);
    duty_wr = 1'b0;
    checks++;
    if (period_tick !== 1'b1) begin
      fails++;
      $display("FAIL boundary_align: period_tick=%b expected 1", period_tick);
    end
    measure(10);
    check_hi("boundary_bypass", 0, 4, 9);
  endtask

  // Center mode, period 8, prescale 1: 16 ticks of 2 clks. cnt holds each
  // value for 2 clks: 0..8 up then 7..1 down, so cnt<4 covers 0,1,2,3,3,2,1
  // = 7 values = 14 clks; cnt_dir is 1 from cnt reaching 8 through cnt 1.
  task automatic test_center();
    write_duty(2'd0, 8'd4);
    center_mode = 1'b1; period = 8'd8; prescale = 8'd1;
    wait_tick("center");
    measure(32);
    check_hi("center_hi", 14, 14, 32);
    check_tick("center_tick", 31);
    checks++;
    if (first_low[0] !== 8 || dir_n !== 16 || first_dir !== 15) begin
      fails++;
      $display("FAIL center_dir: first low %0d dir samples %0d first dir %0d expected 8/16/15",
               first_low[0], dir_n, first_dir);
    end
    center_mode = 1'b0; period = 8'd9; prescale = 8'd0;
  endtask

  // Disable idles outputs but keeps shadow writes; reset is asynchronous
  // and clears the shadow registers.
  task automatic test_disable_reset();
    wait_tick("dis_pre");
    measure(3);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pwm_out !== INV || period_tick !== 1'b0 || cnt_dir !== 1'b0 ||
        dut.u_timebase.cnt_q !== 8'd0) begin
      fails++;
      $display("FAIL disabled_idle: pwm_out=%b tick=%b cnt=%0d expected %b/0/0",
               pwm_out, period_tick, dut.u_timebase.cnt_q, INV);
    end
    write_duty(2'd0, 8'd6);
    enable = 1'b1;
    wait_tick("reenable");
    measure(10);
    check_hi("reenable", 6, 4, 9);
    check_tick("reenable_tick", 9);
    measure(2);
    checks++;
    if (pwm_out !== 3'b101) begin
      fails++;
      $display("FAIL pre_reset_out: pwm_out=%b expected 101", pwm_out);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (pwm_out !== INV || dut.u_timebase.cnt_q !== 8'd0 || cnt_dir !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: pwm_out=%b cnt=%0d expected %b/0",
               pwm_out, dut.u_timebase.cnt_q, INV);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_tick("post_reset");
    measure(10);
    check_hi("shadow_cleared", 0, 0, 0);
    check_tick("post_reset_tick", 9);
  endtask

  // Period change 9->4 mid-period completes the current 10-clk period;
  // a write to channel 3 of 3 is ignored.
  task automatic test_period_change();
    write_duty(2'd0, 8'd3);
    write_duty(2'd1, 8'd5);
    write_duty(2'd2, 8'd8);
    wait_tick("pchg");
    measure(4);
    period = 8'd4;
    measure(6);
    check_tick("pchg_old_len", 5);
    measure(5);
    check_hi("pchg_new", 3, 5, 5);
    check_tick("pchg_new_len", 4);
    write_duty(2'd3, 8'd1);
    wait_tick("sel_oob");
    measure(5);
    check_hi("sel_out_of_range", 3, 5, 5);
  endtask

  initial begin
    test_reset();
    test_edge();
    test_duty_bounds();
    test_shadow_update();
    test_center();
    test_disable_reset();
    test_period_change();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
